// File: rtl/serial_addsub_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : serial_addsub_ctrl_pkg
// Brief  : Shared state encodings and default width for the serial add/sub.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
package serial_addsub_ctrl_pkg;

  localparam int c_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_addsub_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : serial_addsub_if
// Brief  : Operation request / result bundle; ovf exists only when
//          SERIAL_OVF_EN is defined.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
interface serial_addsub_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             cout;
`ifdef SERIAL_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, sub, a, b,
    input  busy, done, result, cout
`ifdef SERIAL_OVF_EN
    , ovf
`endif
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, result, cout
`ifdef SERIAL_OVF_EN
    , ovf
`endif
  );
endinterface
`default_nettype wire

// File: rtl/serial_addsub_ctrl_fulladder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : serial_addsub_ctrl_fulladder
// Brief  : Single-bit full adder cell.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module serial_addsub_ctrl_fulladder (
  input  wire logic i_a,
  input  wire logic i_b,
  input  wire logic i_ci,
  output logic      o_s,
  output logic      o_co
);

  assign o_s  = i_a ^ i_b ^ i_ci;
  assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));

endmodule
`default_nettype wire

// File: rtl/serial_addsub_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : serial_addsub_ctrl
// Brief  : Bit-serial adder/subtractor, one full-adder cell, LSB first over
//          WIDTH cycles. Define SERIAL_OVF_EN to add the signed ovf output.
// Rev    : 1.0 - initial release
// ---------------------------------------------------------------------------
module serial_addsub_ctrl
  import serial_addsub_ctrl_pkg::*;
#(
  parameter int WIDTH = c_DEFAULT_WIDTH
) (
  input  wire logic       clk,
  input  wire logic       reset,
  serial_addsub_if.slave  bus
);

  localparam int              c_CW   = $clog2(WIDTH);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_shift;
  logic             w_last;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_sub;
  logic             r_carry;
  logic [c_CW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  logic             w_cell_b;
  logic             w_sum;
  logic             w_co;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_shift     = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        w_shift = 1'b1;
        if (r_cnt == c_LAST) begin
          w_last      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        // A start held in DONE is taken straight away, skipping IDLE.
        if (bus.start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Subtraction feeds ~B into the cell; the +1 comes from carry-in = sub.
  assign w_cell_b = r_b_sh[0] ^ r_sub;

  serial_addsub_ctrl_fulladder u_fa (
    .i_a  (r_a_sh[0]),
    .i_b  (w_cell_b),
    .i_ci (r_carry),
    .o_s  (w_sum),
    .o_co (w_co)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sub    <= 1'b0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_sub   <= bus.sub;
      r_carry <= bus.sub;
      r_cnt   <= '0;
    end else if (w_shift) begin
      r_a_sh   <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh   <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_carry  <= w_co;
      r_cnt    <= r_cnt + 1'b1;
      r_result <= {w_sum, r_result[WIDTH-1:1]};
      if (w_last) begin
        r_cout <= w_co;
      end
    end
  end

`ifdef SERIAL_OVF_EN
  logic r_ovf;

  // On the last RUN cycle r_carry is the carry into the MSB.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_carry ^ w_co;
    end
  end

  assign bus.ovf = r_ovf;
`endif

  assign bus.busy   = (r_state == S_RUN);
  assign bus.done   = (r_state == S_DONE);
  assign bus.result = r_result;
  assign bus.cout   = r_cout;

endmodule
`default_nettype wire
